// File: rtl/hh_candidate_matvec.sv
// hh_candidate_matvec -- hidden-hidden candidate-gate mat-vec, y = W_hh * h_prev.
//
// Streams one weight word (READ_BURST signed weights) and the matching hidden
// word per cycle, multiply-accumulates each row in a 4-stage pipeline and emits
// one saturated DATA_WIDTH result per row, rows 0..ROWS-1 in order.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           begin one mat-vec, sampled only while idle
//   busy / done     running flag / one-cycle completion pulse
//   w_rd_en/ptr     weight RAM read, ptr = row*WORDS + word, data 1 cycle later
//   h_rd_en/addr    hidden buffer read, addr = word, data 1 cycle later
//   row_valid       strobe qualifying row_idx / row_data
//
// Build option: define MATVEC_ROUND_EN to round half-up before the fractional
// shift; otherwise the shift floors toward -inf. Latency is the same either way.

module hh_mv_lane #(
  parameter int DW = 16
) (
  input  logic [DW-1:0]   w,
  input  logic [DW-1:0]   h,
  output logic [2*DW-1:0] prod
);
  logic signed [2*DW-1:0] ws, hs;
  assign ws   = {{DW{w[DW-1]}}, w};
  assign hs   = {{DW{h[DW-1]}}, h};
  assign prod = ws * hs;  // low 2*DW bits of the extended product are exact
endmodule

module hh_candidate_matvec #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int READ_BURST = 2,
  parameter int ROWS       = 128,
  parameter int COLS       = 128,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               w_rd_en,
  output logic [ADDR_WIDTH-2:0]              w_rd_ptr,
  input  logic [DATA_WIDTH*READ_BURST-1:0]   w_rd_data,
  output logic                               h_rd_en,
  output logic [$clog2(COLS/READ_BURST)-1:0] h_rd_addr,
  input  logic [DATA_WIDTH*READ_BURST-1:0]   h_rd_data,
  output logic                               row_valid,
  output logic [$clog2(ROWS)-1:0]            row_idx,
  output logic [DATA_WIDTH-1:0]              row_data
);
  localparam int WORDS  = COLS / READ_BURST;
  localparam int WB     = $clog2(WORDS);
  localparam int RB     = $clog2(ROWS);
  localparam int PTR_W  = ADDR_WIDTH - 1;
  localparam int PW     = 2*DATA_WIDTH + 1;
  localparam int STAGES = 3;

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = -SAT_HI - ACC_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DW_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] DW_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`ifdef MATVEC_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) << (FRAC_BITS-1);
`else
  localparam logic signed [ACC_WIDTH-1:0] RND = '0;
`endif

  if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(COLS) + 1) begin : g_acc_chk
    $error("ACC_WIDTH too narrow for a full row sum");
  end

  // ---------------- FSM ----------------
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [WB-1:0] word_cnt;
  logic [RB-1:0] row_cnt;
  logic          issue, last_read;
  logic [STAGES:0] vld_pipe;

  assign last_read = (row_cnt == RB'(ROWS-1)) && (word_cnt == WB'(WORDS-1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // The last stage is the output strobe itself, so drain ends once the
  // stages feeding it are empty; that lands DONE right after the last row.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (last_read) state_nxt = S_DRAIN;
      S_DRAIN: if (~|vld_pipe[STAGES-1:0]) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue     = (state == S_ISSUE);
    busy      = (state == S_ISSUE) || (state == S_DRAIN);
    done      = (state == S_DONE);
    w_rd_en   = issue;
    h_rd_en   = issue;
    w_rd_ptr  = PTR_W'({row_cnt, word_cnt});
    h_rd_addr = word_cnt;
  end

  // Counters freeze on the final read so the pointers hold until next start.
  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE && start)) begin
      word_cnt <= '0;
      row_cnt  <= '0;
    end else if (issue && !last_read) begin
      if (word_cnt == WB'(WORDS-1)) begin
        word_cnt <= '0;
        row_cnt  <= row_cnt + RB'(1);
      end else begin
        word_cnt <= word_cnt + WB'(1);
      end
    end
  end

  // ---------------- datapath ----------------
  // Stage k of the tag/valid pipes describes the read issued k+1 cycles ago.
  logic [1:0]          first_pipe;
  logic [STAGES:0]     last_pipe;
  logic [2:0][RB-1:0]  row_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      row_pipe   <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:0], issue};
      first_pipe <= {first_pipe[0], word_cnt == '0};
      last_pipe  <= {last_pipe[STAGES-1:0], word_cnt == WB'(WORDS-1)};
      row_pipe   <= {row_pipe[1:0], row_cnt};
    end
  end

  logic [READ_BURST-1:0][2*DATA_WIDTH-1:0] prod;
  for (genvar k = 0; k < READ_BURST; k++) begin : g_lane
    hh_mv_lane #(.DW(DATA_WIDTH)) u_lane (
      .w    (w_rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .h    (h_rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .prod (prod[k])
    );
  end

  logic [PW-1:0] psum, p;
  always_comb begin
    psum = '0;
    for (int k = 0; k < READ_BURST; k++)
      psum = psum + {prod[k][2*DATA_WIDTH-1], prod[k]};
  end

  logic signed [ACC_WIDTH-1:0] acc, acc_rnd, acc_sh;
  logic [DATA_WIDTH-1:0]       sat_data;

  always_comb begin
    acc_rnd = acc + RND;
    acc_sh  = acc_rnd >>> FRAC_BITS;
    if (acc_sh > SAT_HI)      sat_data = DW_MAX;
    else if (acc_sh < SAT_LO) sat_data = DW_MIN;
    else                      sat_data = acc_sh[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p        <= '0;
      acc      <= '0;
      row_data <= '0;
      row_idx  <= '0;
    end else begin
      if (vld_pipe[0]) p <= psum;
      if (vld_pipe[1])
        acc <= (first_pipe[1] ? '0 : acc) + {{(ACC_WIDTH-PW){p[PW-1]}}, p};
      if (vld_pipe[2] && last_pipe[2]) begin
        row_data <= sat_data;
        row_idx  <= row_pipe[2];
      end
    end
  end

  assign row_valid = vld_pipe[STAGES] & last_pipe[STAGES];

endmodule
